// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: d = a - b - bin, one bit per clock, LSB first.
// Single full-subtractor cell with a borrow flip-flop; start/busy/done handshake.
module serial_subtractor #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] d,
   output logic             bout
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state;
   state_t           state_n;
   logic [WIDTH-1:0] ra;
   logic [WIDTH-1:0] rb;
   logic [WIDTH-1:0] res;
   logic [CW-1:0]    cnt;
   logic             br;
   logic             diff;
   logic             br_n;
   logic             last;

   // Full-subtractor cell on the current LSBs and the stored borrow.
   always_comb begin
      diff = ra[0] ^ rb[0] ^ br;
      br_n = (~ra[0] & rb[0]) | (~(ra[0] ^ rb[0]) & br);
      last = (cnt == LAST);
   end

   // Next-state logic: accept only in IDLE, DONE lasts one cycle.
   always_comb begin
      state_n = state;
      unique case (state)
         IDLE:    if (start) state_n = SHIFT;
         SHIFT:   if (last) state_n = DONE;
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // State register with registered busy/done flags derived from next state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_n;
         busy  <= (state_n == SHIFT);
         done  <= (state_n == DONE);
      end
   end

   // Datapath: load on accept, shift one bit per SHIFT edge, publish at the end.
   always_ff @(posedge clk) begin
      if (rst) begin
         ra   <= '0;
         rb   <= '0;
         res  <= '0;
         cnt  <= '0;
         br   <= 1'b0;
         d    <= '0;
         bout <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  ra  <= a;
                  rb  <= b;
                  br  <= bin;
                  cnt <= '0;
                  res <= '0;
               end
            end
            SHIFT: begin
               ra  <= ra >> 1;
               rb  <= rb >> 1;
               br  <= br_n;
               res <= {diff, res[WIDTH-1:1]};
               cnt <= cnt + 1'b1;
               if (last) begin
                  d    <= {diff, res[WIDTH-1:1]};
                  bout <= br_n;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor.
// Stimulus pushes expected results; a monitor pops them on done.
module tb_serial_subtractor;

   localparam int W = 4;
   localparam int P = 10;

   typedef struct {
      logic [W-1:0] d;
      logic         bo;
      time          t0;
   } exp_t;

   logic         clk;
   logic         rst;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         bin;
   logic         busy;
   logic         done;
   logic [W-1:0] d;
   logic         bout;

   int   checks;
   int   errors;
   exp_t q[$];
   logic [W-1:0] hold_d;
   logic         hold_b;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .bin   (bin),
      .busy  (busy),
      .done  (done),
      .d     (d),
      .bout  (bout)
   );

   initial begin
      clk = 1'b0;
      forever #(P/2) clk = ~clk;
   end

   function automatic exp_t model(input int ia, input int ib, input int ibin);
      exp_t m;
      int   r;
      r    = ia - ib - ibin;
      m.d  = r[W-1:0];
      m.bo = (ia < ib + ibin);
      m.t0 = 0;
      return m;
   endfunction

   // Reset discards anything in flight and zeroes the held result.
   always @(posedge clk) begin
      if (rst) begin
         q.delete();
         hold_d = '0;
         hold_b = 1'b0;
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         checks++;
         if (busy && done) begin
            errors++;
            $display("FAIL busy_done_overlap busy=%0b done=%0b want not both", busy, done);
         end
         if (done) begin
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_done done=1 want 0 at t=%0t", $time);
            end else begin
               exp_t e;
               e = q.pop_front();
               checks++;
               if (d !== e.d || bout !== e.bo) begin
                  errors++;
                  $display("FAIL result d=%0d bout=%0b want d=%0d bout=%0b",
                           d, bout, e.d, e.bo);
               end
               checks++;
               if ($time - e.t0 != W * P + P / 2) begin
                  errors++;
                  $display("FAIL latency got=%0t want=%0d", $time - e.t0,
                           W * P + P / 2);
               end
               hold_d = e.d;
               hold_b = e.bo;
            end
         end else begin
            checks++;
            if (d !== hold_d || bout !== hold_b) begin
               errors++;
               $display("FAIL hold d=%0d bout=%0b want d=%0d bout=%0b",
                        d, bout, hold_d, hold_b);
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [W+2:0] got, input logic [W+2:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h", nm, got, want);
      end
   endtask

   task automatic issue(input int ia, input int ib, input int ibin);
      exp_t e;
      a     = W'(ia);
      b     = W'(ib);
      bin   = ibin[0];
      start = 1'b1;
      @(posedge clk);
      e    = model(ia, ib, ibin);
      e.t0 = $time;
      q.push_back(e);
      #1;
      start = 1'b0;
      a     = W'($urandom);
      b     = W'($urandom);
      bin   = 1'($urandom);
   endtask

   task automatic drain();
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (q.size() == 0) break;
      end
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL timeout pending=%0d want 0", q.size());
         q.delete();
      end
      @(posedge clk);
      #1;
   endtask

   task automatic run(input int ia, input int ib, input int ibin);
      issue(ia, ib, ibin);
      for (int k = 0; k < W; k++) begin
         @(negedge clk);
         chk("busy_high", {6'd0, busy}, 7'd1);
      end
      drain();
   endtask

   initial begin
      int n;
      checks = 0;
      errors = 0;
      rst    = 1'b1;
      start  = 1'b0;
      a      = '0;
      b      = '0;
      bin    = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_outs", {busy, done, bout, d}, '0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      run(0, 0, 0);
      run(2, 3, 0);
      run(2, 3, 1);
      run(8, 7, 0);
      run(8, 7, 1);
      run(0, 0, 1);
      run(15, 15, 1);
      run(15, 0, 0);
      run(0, 15, 1);

      // start during busy and during DONE is ignored
      issue(8, 7, 0);
      @(posedge clk);
      #1;
      start = 1'b1;
      a     = 4'd5;
      b     = 4'd1;
      @(posedge clk);
      #1;
      start = 1'b0;
      n     = 0;
      while (!done && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("done_seen", {6'd0, done}, 7'd1);
      start = 1'b1;
      a     = 4'd5;
      b     = 4'd1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (6) begin
         @(negedge clk);
         chk("ignored_busy", {6'd0, busy}, 7'd0);
         chk("ignored_d", {3'd0, d}, 7'd1);
      end
      @(posedge clk);
      #1;

      // reset in the 3rd busy cycle aborts the operation
      issue(9, 4, 0);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("abort_outs", {busy, done, bout, d}, '0);
      repeat (8) @(negedge clk);
      @(posedge clk);
      #1;
      run(2, 3, 0);

      for (int i = 0; i < 24; i++) begin
         run(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
             int'($urandom_range(0, 1)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
